// File: rtl/ara_pkg.sv
// Shared vector-lane types: VRF word addresses, instruction IDs, data/strobe widths
// and the result-queue payload carried from the functional units to the VRF.
package ara_pkg;

  localparam int unsigned NrLanes        = 0;
  localparam int unsigned ELEN           = 64;
  localparam int unsigned NrVInsn        = 8;
  localparam int unsigned VaddrWidth     = (NrLanes > 1) ? 16 - $clog2(NrLanes) : 16;
  localparam int unsigned NrResultQueues = 5;

  typedef logic [ELEN-1:0]            elen_t;
  typedef logic [ELEN/8-1:0]          strb_t;
  typedef logic [$clog2(NrVInsn)-1:0] vid_t;
  typedef logic [VaddrWidth-1:0]      vaddr_t;

  typedef enum logic [2:0] {
    AluRes   = 3'd0,
    MfpuRes  = 3'd1,
    MaskuRes = 3'd2,
    SlduRes  = 3'd3,
    VlduRes  = 3'd4
  } result_queue_e;

  typedef struct packed {
    vaddr_t addr;
    vid_t   id;
    elen_t  wdata;
    strb_t  be;
  } result_entry_t;

  // Index width that never collapses to zero bits.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? unsigned'($clog2(n)) : 1;
  endfunction

endpackage

// File: rtl/result_buffer.sv
// Small per-source result FIFO with flush; flush and reset empty it on the next edge.
module result_buffer
  import ara_pkg::*;
#(
  parameter int unsigned Depth = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic          push,
  input  logic          pop,
  input  result_entry_t wdata,
  output result_entry_t rdata,
  output logic          full,
  output logic          empty
);

  localparam int unsigned PtrW = idx_width(Depth);
  localparam int unsigned CntW = idx_width(Depth + 1);

  result_entry_t   mem [Depth];
  logic [PtrW-1:0] rd_q, wr_q;
  logic [CntW-1:0] cnt_q;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(Depth - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full  = (cnt_q == CntW'(Depth));
  assign empty = (cnt_q == '0);
  assign rdata = mem[rd_q];

  // Storage is not reset: occupancy alone defines which entries are live.
  always_ff @(posedge clk) begin
    if (push) mem[wr_q] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (push) wr_q <= ptr_inc(wr_q);
      if (pop)  rd_q <= ptr_inc(rd_q);
      case ({push, pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

endmodule

// File: rtl/vrf_result_queues_stage.sv
// Lane writeback stage: buffers VFU results per source and round-robins the heads
// onto the single VRF write port; the pointer advances only on accepted writes.
module vrf_result_queues_stage
  import ara_pkg::*;
#(
  parameter int unsigned ResultBufDepth = 2
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic [NrResultQueues-1:0] result_req_i,
  input  vaddr_t                    result_addr_i  [NrResultQueues],
  input  vid_t                      result_id_i    [NrResultQueues],
  input  elen_t                     result_wdata_i [NrResultQueues],
  input  strb_t                     result_be_i    [NrResultQueues],
  output logic [NrResultQueues-1:0] result_gnt_o,
  output logic [NrResultQueues-1:0] result_done_o,
  input  logic [NrResultQueues-1:0] result_flush_i,
  output logic                      vrf_req_o,
  output vaddr_t                    vrf_addr_o,
  output elen_t                     vrf_wdata_o,
  output strb_t                     vrf_be_o,
  output vid_t                      vrf_id_o,
  output result_queue_e             vrf_src_o,
  input  logic                      vrf_gnt_i
);

  localparam int unsigned NQ   = NrResultQueues;
  localparam int unsigned SrcW = $bits(result_queue_e);

  logic [NQ-1:0]   full, empty, cand, pop;
  result_entry_t   in_entry [NQ];
  result_entry_t   heads    [NQ];
  logic [SrcW-1:0] rr_q, winner, idx;
  logic [SrcW:0]   sum;
  logic            found;

  // Acceptance looks only at registered occupancy, never at this cycle's pop.
  assign result_gnt_o = result_req_i & ~full & ~result_flush_i;
  assign cand         = ~empty & ~result_flush_i;

  for (genvar k = 0; k < NQ; k++) begin : g_buf
    assign in_entry[k] = '{addr:  result_addr_i[k],
                           id:    result_id_i[k],
                           wdata: result_wdata_i[k],
                           be:    result_be_i[k]};

    result_buffer #(.Depth(ResultBufDepth)) i_buf (
      .clk   (clk_i),
      .rst   (rst_i),
      .flush (result_flush_i[k]),
      .push  (result_gnt_o[k]),
      .pop   (pop[k]),
      .wdata (in_entry[k]),
      .rdata (heads[k]),
      .full  (full[k]),
      .empty (empty[k])
    );
  end

  // Round-robin search starting at rr_q.
  always_comb begin
    winner = rr_q;
    found  = 1'b0;
    sum    = '0;
    idx    = '0;
    for (int unsigned off = 0; off < NQ; off++) begin
      sum = {1'b0, rr_q} + (SrcW+1)'(off);
      if (sum >= (SrcW+1)'(NQ)) sum = sum - (SrcW+1)'(NQ);
      idx = sum[SrcW-1:0];
      if (!found && cand[idx]) begin
        winner = idx;
        found  = 1'b1;
      end
    end
  end

  always_comb begin
    vrf_req_o   = found;
    vrf_src_o   = AluRes;
    vrf_addr_o  = '0;
    vrf_wdata_o = '0;
    vrf_be_o    = '0;
    vrf_id_o    = '0;
    pop         = '0;
    if (found) begin
      vrf_src_o   = result_queue_e'(winner);
      vrf_addr_o  = heads[winner].addr;
      vrf_wdata_o = heads[winner].wdata;
      vrf_be_o    = heads[winner].be;
      vrf_id_o    = heads[winner].id;
    end
    for (int unsigned k = 0; k < NQ; k++) begin
      pop[k] = found & vrf_gnt_i & (winner == SrcW'(k));
    end
  end

  assign result_done_o = pop;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rr_q <= '0;
    end else if (found && vrf_gnt_i) begin
      rr_q <= (winner == SrcW'(NQ - 1)) ? '0 : winner + 1'b1;
    end
  end

endmodule
